// File: rtl/ft245_bus_if.sv
// FT245 bus controller signal bundle: SoC-side TX/RX byte streams plus the
// FIFO pin-side strobes, data and synchronized status flags.
interface ft245_bus_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] uart_rdata;
  logic [7:0] uart_wdata;
  logic       uart_txe;
  logic       uart_rxf;
  logic       uart_wr;
  logic       uart_rd;

  // Controller side
  modport master (
    input  tx_valid, tx_data, rx_ready, uart_rdata, uart_txe, uart_rxf,
    output tx_ready, rx_valid, rx_data, uart_wdata, uart_wr, uart_rd
  );

  // SoC / pad side
  modport slave (
    output tx_valid, tx_data, rx_ready, uart_rdata, uart_txe, uart_rxf,
    input  tx_ready, rx_valid, rx_data, uart_wdata, uart_wr, uart_rd
  );
endinterface

// File: rtl/ft245_bus_ctrl.sv
// FT245 parallel FIFO sequencer: one-entry TX/RX holding buffers, fair
// read/write arbitration and registered, mutually exclusive RD/WR strobes
// followed by a fixed status-recovery window.
module ft245_bus_ctrl #(
  parameter int RD_CYCLES      = 4,
  parameter int WR_CYCLES      = 4,
  parameter int RECOVER_CYCLES = 6
) (
  input  logic          clk,
  input  logic          reset,
  ft245_bus_if.master   bus,
  output logic          busy
);

  localparam int MAX_RW = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAX_N  = (MAX_RW > RECOVER_CYCLES) ? MAX_RW : RECOVER_CYCLES;
  localparam int CW     = $clog2(MAX_N) + 1;

  typedef enum logic [1:0] {IDLE, RD_PULSE, WR_PULSE, RECOVER} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rd_q, rd_n;
  logic          wr_q, wr_n;
  logic [7:0]    wdata_q;
  logic          last_wr, last_wr_n;
  logic          tx_full;
  logic [7:0]    tx_buf;
  logic          rx_full;
  logic [7:0]    rx_q;
  logic          can_rd, can_wr;
  logic          rx_load, tx_clear, wdata_load;

  assign bus.tx_ready   = ~tx_full;
  assign bus.rx_valid   = rx_full;
  assign bus.rx_data    = rx_q;
  assign bus.uart_wdata = wdata_q;
  assign bus.uart_wr    = wr_q;
  assign bus.uart_rd    = rd_q;
  assign busy           = (state != IDLE);

  // Next-state, next-strobe and buffer-control decode
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rd_n       = 1'b0;
    wr_n       = 1'b0;
    last_wr_n  = last_wr;
    rx_load    = 1'b0;
    tx_clear   = 1'b0;
    wdata_load = 1'b0;
    can_rd     = ~bus.uart_rxf & ~rx_full;
    can_wr     = ~bus.uart_txe & tx_full;
    case (state)
      IDLE: begin
        // Read wins when it is alone or when the previous grant was a write
        if (can_rd && (!can_wr || last_wr)) begin
          state_n   = RD_PULSE;
          cnt_n     = CW'(RD_CYCLES - 1);
          rd_n      = 1'b1;
          last_wr_n = 1'b0;
        end else if (can_wr) begin
          state_n    = WR_PULSE;
          cnt_n      = CW'(WR_CYCLES - 1);
          wr_n       = 1'b1;
          wdata_load = 1'b1;
          last_wr_n  = 1'b1;
        end
      end
      RD_PULSE: begin
        if (cnt == '0) begin
          rx_load = 1'b1;
          state_n = RECOVER;
          cnt_n   = CW'(RECOVER_CYCLES - 1);
        end else begin
          cnt_n = cnt - 1'b1;
          rd_n  = 1'b1;
        end
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          tx_clear = 1'b1;
          state_n  = RECOVER;
          cnt_n    = CW'(RECOVER_CYCLES - 1);
        end else begin
          cnt_n = cnt - 1'b1;
          wr_n  = 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, registered strobes and write data
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      last_wr <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      last_wr <= last_wr_n;
      if (wdata_load) wdata_q <= tx_buf;
    end
  end

  // One-entry TX and RX holding buffers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full <= 1'b0;
      tx_buf  <= '0;
      rx_full <= 1'b0;
      rx_q    <= '0;
    end else begin
      if (tx_clear) begin
        tx_full <= 1'b0;
      end else if (bus.tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_buf  <= bus.tx_data;
      end
      if (rx_load) begin
        rx_full <= 1'b1;
        rx_q    <= bus.uart_rdata;
      end else if (rx_full && bus.rx_ready) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ft245_bus_ctrl.md
Name: ft245_bus_ctrl

Overview:
- Sequencer for the FT245-style parallel UART FIFO pins.
- Converts SoC-side valid/ready byte streams (TX and RX) into correctly timed, mutually exclusive RD/WR strobe cycles on the shared 8-bit bus.
- Sits inside SicoSOC between the CPU/MMIO UART registers and the `io_uart_*` pins.
- Arbitrates read vs. write fairly; enforces strobe width and status-recovery time; `uart_txe`/`uart_rxf` arrive already 2-flop synchronized.

Parameters:
- RD_CYCLES, 4, width of `uart_rd` pulse in clk cycles; data sampled in last cycle; min 2.
- WR_CYCLES, 4, width of `uart_wr` pulse in clk cycles; min 1.
- RECOVER_CYCLES, 6, idle cycles after any strobe before status is re-sampled; min 3 (covers 2-flop sync latency plus FT245 status update).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  SoC offers TX byte.
- tx_data  in  8  TX byte.
- tx_ready  out  1  TX holding register empty; transfer on `tx_valid & tx_ready`.
- rx_valid  out  1  RX holding register full.
- rx_data  out  8  received byte, stable while `rx_valid`.
- rx_ready  in  1  SoC consumes byte; transfer on `rx_valid & rx_ready`.
- uart_rdata  in  8  bus read value from pad.
- uart_wdata  out  8  byte to drive; pad drives bus while `uart_wr`=1.
- uart_txe  in  1  synchronized TXE#; 0 = FIFO can accept a byte.
- uart_rxf  in  1  synchronized RXF#; 0 = FIFO has a byte.
- uart_wr  out  1  active-high write strobe (inverted at pad).
- uart_rd  out  1  active-high read strobe (inverted at pad).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - Outputs: `uart_wr`=0, `uart_rd`=0, `uart_wdata`=0, `rx_valid`=0, `rx_data`=0, `tx_ready`=1, `busy`=0.
  - Internal: state=IDLE, counter=0, `last_grant`=WRITE (so first contention goes to read).
- Strobe outputs are registered; no combinational path from any input to `uart_wr`/`uart_rd`.
- TX buffer:
  - One entry; `tx_ready` = ~`tx_full`.
  - Accepting sets `tx_full` next edge and latches `tx_data`.
  - No accept in the same cycle the FSM clears the buffer (`tx_ready` is 0 then).
- RX buffer:
  - One entry; `rx_valid` = `rx_full`.
  - `rx_valid & rx_ready` clears it next edge.
- Eligibility (evaluated in IDLE only):
  - can_rd = ~`uart_rxf` & ~`rx_full`.
  - can_wr = ~`uart_txe` & `tx_full`.
- Arbitration:
  - Only one eligible: take it.
  - Both eligible: grant opposite of `last_grant`.
  - Update `last_grant` on every grant.
- FSM states: IDLE, RD_PULSE, WR_PULSE, RECOVER.
  - IDLE -> RD_PULSE: `uart_rd`=1 from the next edge, counter=RD_CYCLES-1.
  - IDLE -> WR_PULSE: `uart_wdata` <= tx buffer and `uart_wr`=1 on the same edge, counter=WR_CYCLES-1.
  - RD_PULSE: hold `uart_rd`=1 for exactly RD_CYCLES cycles. In the final cycle (counter=0), capture `uart_rdata` into `rx_data`, set `rx_full`, drop `uart_rd`, enter RECOVER.
  - WR_PULSE: hold `uart_wr`=1 for exactly WR_CYCLES cycles with `uart_wdata` stable. On exit, drop `uart_wr`, clear `tx_full`, enter RECOVER. `uart_wdata` holds its value until the next write.
  - RECOVER: both strobes 0 for exactly RECOVER_CYCLES cycles, then IDLE. Status inputs are ignored throughout.
  - Neither eligible: remain IDLE.
- Invariants:
  - `uart_rd` & `uart_wr` never 1 together.
  - Back-to-back strobes are separated by ≥ RECOVER_CYCLES low cycles.
  - Minimum transaction period = pulse + RECOVER_CYCLES (+1 IDLE cycle).
- Counter: width = clog2(max(RD_CYCLES, WR_CYCLES, RECOVER_CYCLES)) + 1; loads N-1 and counts down.
- Status change during pulse: `uart_rxf`/`uart_txe` changes mid-pulse are ignored; the transaction completes.
- Reset mid-operation: on the next edge, strobes drop, both buffers are cleared and state returns to IDLE. A partially strobed byte is lost (accepted).
- A read is never started while `rx_full`=1, so RX overrun is impossible. The FT245 holds data instead.

Test Plan:
- Single write: `uart_txe`=0, push 0xA5. Required: `tx_ready` falls next edge; `uart_wr`=1 for exactly 4 cycles with `uart_wdata`=0xA5; then 6 low cycles; `tx_ready`=1 after the pulse.
- Single read: `uart_rxf`=0, `uart_rdata`=0x3C, `rx_ready`=0. Required: `uart_rd`=1 for 4 cycles; `rx_valid`=1 with `rx_data`=0x3C; no further `uart_rd` while `rx_valid` stays 1, even with `uart_rxf` held 0.
- Contention fairness: `uart_rxf`=0, `uart_txe`=0, TX byte pending, `rx_ready`=1 always. Required: strobe order RD, WR, RD, WR…; never overlapping; ≥6 idle cycles between each.
- Back-pressure: `uart_txe`=1 with TX byte 0x11 pending. Required: `uart_wr` stays 0. Drop `uart_txe` to 0: write of 0x11 starts within 2 cycles.
- Reset mid-write: assert `reset` on cycle 2 of a WR_PULSE. Required: next edge `uart_wr`=0, `tx_ready`=1, `busy`=0; no strobe until new stimulus.
- Parameter sweep: RD_CYCLES=2, WR_CYCLES=1, RECOVER_CYCLES=3. Required: pulse widths 2/1 and gaps of 3 cycles, checked by assertion on every transaction.
